// File: rtl/fifo_stream_pkg.sv
// Shared constants and occupancy encoding for the FIFO-to-stream adapter.
// Used by the RTL and the testbench alike.
package fifo_stream_pkg;

    localparam int BUF_DEPTH = 3;
    localparam int PTR_W     = 2;
    localparam int CNT_W     = 2;
    localparam int STATS_W   = 32;

    typedef enum logic [CNT_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2,
        FULL  = 2'd3
    } occ_e;

    // Pointers step 0 -> 1 -> 2 -> 0; the fourth code is never used.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_stream_buf.sv
// Three-entry in-order storage with wrapping read/write pointers.
// Occupancy tracking lives in the parent; push/pop are trusted to be legal.
module fifo_stream_buf
    import fifo_stream_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are live, so stale contents are never observed as valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_adapter.sv
// Adapts a latency-1 read FIFO to a valid/ready stream via a 3-entry skid buffer.
// Define FIFO_STREAM_STATS_EN to enable the accepted-beat counter on beat_cnt.
module fifo_stream_adapter
    import fifo_stream_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               fifo_read,
    input  logic [DWIDTH-1:0]  fifo_dout,
    input  logic               fifo_empty,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [DWIDTH-1:0]  m_data,
    output logic [STATS_W-1:0] beat_cnt
);

    occ_e           occ;
    occ_e           occ_next;
    logic           inflight;
    logic           accept;
    logic [CNT_W:0] committed;

    // A read is issued only if its word is guaranteed a slot, so the
    // decision never waits on m_ready.
    assign committed = {1'b0, occ} + {{CNT_W{1'b0}}, inflight};
    assign fifo_read = rst_n && !fifo_empty && (committed <= (CNT_W + 1)'(2));

    assign m_valid = (occ != EMPTY);
    assign accept  = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ      <= EMPTY;
            inflight <= 1'b0;
        end else begin
            occ      <= occ_next;
            inflight <= fifo_read;
        end
    end

    // NOTE: occ_next gets a default before the case so every path assigns it
    // and no latch is inferred.
    always_comb begin
        occ_next = occ;
        case (occ)
            EMPTY: begin
                if (inflight) occ_next = ONE;
            end
            ONE: begin
                if (inflight && !accept)      occ_next = TWO;
                else if (!inflight && accept) occ_next = EMPTY;
            end
            TWO: begin
                if (inflight && !accept)      occ_next = FULL;
                else if (!inflight && accept) occ_next = ONE;
            end
            FULL: begin
                if (!inflight && accept) occ_next = TWO;
            end
        endcase
    end

    fifo_stream_buf #(
        .DWIDTH (DWIDTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .pop   (accept),
        .wdata (fifo_dout),
        .rdata (m_data)
    );

`ifdef FIFO_STREAM_STATS_EN
    logic [STATS_W-1:0] beat_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n)      beat_cnt_q <= '0;
        else if (accept) beat_cnt_q <= beat_cnt_q + 1'b1;
    end

    assign beat_cnt = beat_cnt_q;
`else
    assign beat_cnt = '0;
`endif

    // The issue rule above makes a capture into a full buffer unreachable.
    capture_at_full_a: assert property (
        @(posedge clk) disable iff (!rst_n) !(inflight && occ == FULL)
    );

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Randomised scoreboard bench for fifo_stream_adapter with an upstream FIFO model.
// Beat-counter expectations follow FIFO_STREAM_STATS_EN.
module tb_fifo_stream_adapter;
    import fifo_stream_pkg::*;

    localparam int DW = 32;

`ifdef FIFO_STREAM_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               fifo_read;
    logic [DW-1:0]      fifo_dout = '0;
    logic               fifo_empty = 1'b1;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic [DW-1:0]      m_data;
    logic [STATS_W-1:0] beat_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int n_reads = 0;
    int beats_seen = 0;

    logic [DW-1:0]      src_q[$];
    logic [DW-1:0]      exp_q[$];
    logic               rd_pending = 1'b0;
    logic [DW-1:0]      rd_word = '0;
    logic [STATS_W-1:0] beat_model = '0;
    logic               prev_stall = 1'b0;
    logic [DW-1:0]      prev_data = '0;

    always #5 clk = ~clk;

    fifo_stream_adapter #(.DWIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_read  (fifo_read),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .beat_cnt   (beat_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Upstream FIFO model: words leave src_q when read and become the
    // expected stream; read data appears on fifo_dout one cycle later.
    task automatic drive_cycle(input bit gap, input bit ready);
        @(negedge clk);
        if (rd_pending) fifo_dout = rd_word;
        fifo_empty = (src_q.size() == 0) || gap;
        m_ready    = ready;
        #1;
        check("no_read_when_empty", 64'(fifo_read && fifo_empty), 64'(0));
        if (fifo_read && !fifo_empty) begin
            rd_word = src_q.pop_front();
            exp_q.push_back(rd_word);
            rd_pending = 1'b1;
            n_reads++;
        end else begin
            rd_pending = 1'b0;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        fifo_empty = 1'b1;
        m_ready = 1'b0;
        #1;
        check("read_forced_in_reset", 64'(fifo_read), 64'(0));
        exp_q.delete();
        rd_pending = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_fifo_read", 64'(fifo_read), 64'(0));
        check("rst_beat_cnt", 64'(beat_cnt), 64'(0));
    endtask

    task automatic drain(input int budget, input int gap_pct, input int ready_pct);
        int n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            drive_cycle($urandom_range(0, 99) < gap_pct, $urandom_range(0, 99) < ready_pct);
            n++;
        end
        check("drain_complete", 64'(src_q.size() + exp_q.size()), 64'(0));
    endtask

    // Monitor: scoreboard pops, hold-under-backpressure and beat counter.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_stall = 1'b0;
                beat_model = '0;
            end else begin
                check("beat_cnt", 64'(beat_cnt), STATS_ON ? 64'(beat_model) : 64'(0));
                if (prev_stall) begin
                    check("hold_valid", 64'(m_valid), 64'(1));
                    check("hold_data", 64'(m_data), 64'(prev_data));
                end
                if (m_valid && m_ready) begin
                    check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0) check("beat_data", 64'(m_data), 64'(exp_q.pop_front()));
                    beat_model = beat_model + 1'b1;
                    beats_seen++;
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int r0;

        // Single word
        src_q.delete();
        reset_dut();
        src_q.push_back(32'hA5A5_A5A5);
        for (int c = 0; c < 5; c++) begin
            drive_cycle(1'b0, 1'b1);
            check($sformatf("single_read_c%0d", c), 64'(fifo_read), 64'(c == 0));
            check($sformatf("single_valid_c%0d", c), 64'(m_valid), 64'(c == 2));
            if (c == 2) check("single_data", 64'(m_data), 64'(32'hA5A5_A5A5));
        end
        check("single_beat_cnt", 64'(beat_cnt), STATS_ON ? 64'(1) : 64'(0));

        // Streaming, no bubbles
        src_q.delete();
        reset_dut();
        for (int i = 0; i < 16; i++) src_q.push_back(DW'(i));
        for (int c = 0; c < 19; c++) begin
            drive_cycle(1'b0, 1'b1);
            check($sformatf("stream_valid_c%0d", c), 64'(m_valid), 64'(c >= 2 && c <= 17));
            if (c >= 2 && c <= 17) check("stream_data", 64'(m_data), 64'(c - 2));
        end

        // Backpressure
        src_q.delete();
        reset_dut();
        for (int i = 0; i < 8; i++) src_q.push_back(DW'(i));
        r0 = n_reads;
        b0 = beats_seen;
        for (int c = 0; c < 10; c++) drive_cycle(1'b0, 1'b0);
        check("bp_reads", 64'(n_reads - r0), 64'(3));
        check("bp_occ", 64'(dut.occ), 64'(FULL));
        check("bp_valid", 64'(m_valid), 64'(1));
        check("bp_data", 64'(m_data), 64'(0));
        drain(200, 0, 100);
        check("bp_beats", 64'(beats_seen - b0), 64'(8));

        // Reset mid-stream with cnt=2 and a word in flight
        src_q.delete();
        reset_dut();
        for (int i = 0; i < 8; i++) src_q.push_back(DW'(32'h100 + i));
        for (int c = 0; c < 3; c++) drive_cycle(1'b0, 1'b0);
        @(negedge clk);
        if (rd_pending) fifo_dout = rd_word;
        rst_n = 1'b0;
        fifo_empty = 1'b0;
        m_ready = 1'b0;
        #1;
        check("mid_occ", 64'(dut.occ), 64'(TWO));
        check("mid_inflight", 64'(dut.inflight), 64'(1));
        check("mid_read_forced", 64'(fifo_read), 64'(0));
        exp_q.delete();
        rd_pending = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        b0 = beats_seen;
        drive_cycle(1'b0, 1'b1);
        check("mid_valid_after_reset", 64'(m_valid), 64'(0));
        drain(200, 0, 100);
        check("mid_beats", 64'(beats_seen - b0), 64'(5));

        // Beat counter wrap
        src_q.delete();
        reset_dut();
`ifdef FIFO_STREAM_STATS_EN
        @(negedge clk);
        fifo_empty = 1'b1;
        m_ready = 1'b0;
        #1;
        force dut.beat_cnt_q = 32'hFFFF_FFFE;
        beat_model = 32'hFFFF_FFFE;
        #2;
        release dut.beat_cnt_q;
        check("wrap_preload", 64'(beat_cnt), 64'(32'hFFFF_FFFE));
`endif
        for (int i = 0; i < 3; i++) src_q.push_back(DW'(32'h200 + i));
        drain(100, 0, 100);
        check("wrap_beat_cnt", 64'(beat_cnt), STATS_ON ? 64'(1) : 64'(0));

        // Random traffic
        src_q.delete();
        reset_dut();
        for (int i = 0; i < 1000; i++) src_q.push_back(DW'($urandom));
        b0 = beats_seen;
        drain(20000, 25, 50);
        check("rand_beats", 64'(beats_seen - b0), 64'(1000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_stream_adapter.md
FIFO_STREAM_ADAPTER -- requirements
Module: fifo_stream_adapter

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, giving the data width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, shared with the FIFO read side.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port fifo_read, output, 1 bit: read strobe to the upstream FIFO, which has read latency 1.
REQ-005 The block SHALL have port fifo_dout, input, DWIDTH bits: FIFO read data, valid in the cycle after fifo_read.
REQ-006 The block SHALL have port fifo_empty, input, 1 bit: FIFO empty flag.
REQ-007 The block SHALL have port m_valid, output, 1 bit: stream data valid.
REQ-008 The block SHALL have port m_ready, input, 1 bit: stream consumer ready.
REQ-009 The block SHALL have port m_data, output, DWIDTH bits: stream data.
REQ-010 The block SHALL have port beat_cnt, output, 32 bits: accepted-beat count (see Configuration).

Function
REQ-011 The block SHALL hold a 3-entry in-order buffer with a registered occupancy cnt (0..3) and a registered inflight bit.
- inflight SHALL be set in the cycle after fifo_read was asserted, and clear otherwise.
REQ-012 fifo_read SHALL equal !fifo_empty && (cnt + inflight <= 2).
- fifo_read SHALL NOT depend combinationally on m_ready.
REQ-013 When inflight=1, fifo_dout SHALL be written to the buffer tail at the end of that cycle; fifo_dout SHALL be ignored when inflight=0.
REQ-014 m_valid SHALL equal (cnt != 0), and m_data SHALL equal the buffer head entry.
- There is no bypass path, so first-word latency is 2 cycles from fifo_read to m_valid.
REQ-015 A beat SHALL be accepted when m_valid && m_ready; acceptance SHALL pop the head at the clock edge.
REQ-016 Capture and pop in the same cycle SHALL leave cnt unchanged and SHALL preserve data order.
REQ-017 While m_valid=1 and m_ready=0, m_data SHALL be held stable and m_valid SHALL stay 1.
REQ-018 The occupancy states SHALL be EMPTY(0), ONE(1), TWO(2) and FULL(3).
- cnt+1 on capture without pop; cnt-1 on pop without capture.
- Capture at FULL is impossible by construction; an assertion SHALL flag it in simulation.
REQ-019 With m_ready held 1 and the FIFO non-empty, the block SHALL sustain 1 beat per cycle with no bubbles after the initial latency.
REQ-020 Buffer pointers SHALL be 2 bits and SHALL wrap modulo 3 (2 -> 0).

Reset
REQ-021 With rst_n=0 at a clock edge, cnt, inflight and the pointers SHALL go to 0, and m_valid, fifo_read and beat_cnt SHALL read 0 in the following cycle.
- fifo_read SHALL be forced to 0 while rst_n=0.
REQ-022 Reset in mid-operation SHALL discard buffered and in-flight words; after reset, the FIFO word still presented on fifo_dout SHALL NOT be captured.
REQ-023 Buffer data storage SHALL NOT require reset.

Configuration
REQ-024 With macro FIFO_STREAM_STATS_EN defined, beat_cnt SHALL increment by 1 per accepted beat and SHALL wrap from 0xFFFFFFFF to 0.
REQ-025 Without FIFO_STREAM_STATS_EN, beat_cnt SHALL be constant 0 and no counter logic SHALL be synthesized; the port SHALL remain present.

Structure
REQ-026 Package fifo_stream_pkg SHALL hold the following, shared by both implementation and bench:
- BUF_DEPTH=3 and PTR_W=2;
- CNT_W=2;
- the occupancy state encoding EMPTY/ONE/TWO/FULL;
- STATS_W=32.
REQ-027 The 3-entry storage and its pointers SHALL be sub-module fifo_stream_buf (ports: push, pop, wdata, rdata).
- Occupancy and read-issue control SHALL stay in the top level.

Verification
REQ-028 Single word: FIFO holds 0xA5A5A5A5, m_ready=1 -> fifo_read asserted in cycle 0, m_valid=1 with m_data=0xA5A5A5A5 in cycle 2 only, beat_cnt=1 (stats enabled).
REQ-029 Streaming: 16 words 0..15 preloaded, m_ready=1 -> 16 consecutive beats 0..15 in cycles 2..17, no gaps.
REQ-030 Backpressure: 8 words, m_ready=0 for 10 cycles -> fifo_read stops after 3 reads, cnt=3, m_data=0 held stable; after m_ready=1, words 0..7 arrive in order with none lost.
REQ-031 Random m_ready (50%) with random fifo_empty gaps over 1000 words -> output sequence equals input sequence and fifo_read never asserts while fifo_empty=1.
REQ-032 Reset in mid-stream: rst_n=0 for 1 cycle with cnt=2 and inflight=1 -> m_valid=0 next cycle, stale word not output, new words resume from FIFO order.
REQ-033 Wrap check: preload beat_cnt to 0xFFFFFFFE via force, accept 3 beats -> beat_cnt=1 with macro defined; beat_cnt=0 throughout without it.
